// File: rtl/mips_pkg.sv
// Shared MIPS constants: instruction width, NOP word and opcode/funct encodings.
package mips_pkg;

  localparam int unsigned INST_W = 32;
  localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_BEQ   = 6'h04,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FN_ADD = 6'h20,
    FN_SUB = 6'h22,
    FN_AND = 6'h24,
    FN_OR  = 6'h25
  } funct_e;

  function automatic logic [INST_W-1:0] encode_r(input logic [4:0] rs,
                                                 input logic [4:0] rt,
                                                 input logic [4:0] rd,
                                                 input funct_e     fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

endpackage

// File: rtl/mem_palavras_1w1r.sv
// Word array with synchronous write and combinational read; out-of-range
// accesses are dropped on write and read back as zero.
module mem_palavras_1w1r #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i && (32'(wr_addr_i) < DEPTH)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data_o = '0;
    if (32'(rd_addr_i) < DEPTH) begin
      rd_data_o = mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/memoria_instrucoes_param.sv
// Clocked instruction memory: valid/ready fetch with a one-entry response
// register, program-load port, fault flags and a saturating fetch counter.
module memoria_instrucoes_param
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] instrucao,
  output logic              erro_alinhamento,
  output logic              erro_faixa,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [CNT_W-1:0]  num_buscas
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDX_W-1:0]  fetch_idx, load_idx;
  logic              fetch_in_range, load_in_range;
  logic              accept, load_we;
  logic [DATA_W-1:0] rd_data;
  logic              unused_load_lsb;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              al_q, al_d;
  logic              fx_q, fx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign fetch_idx       = fetch_addr[ADDR_W-1:2];
  assign load_idx        = load_addr[ADDR_W-1:2];
  assign unused_load_lsb = ^load_addr[1:0];
  // Range test on the full index so high address bits cannot alias into the array.
  assign fetch_in_range  = 32'(fetch_idx) < DEPTH;
  assign load_in_range   = 32'(load_idx) < DEPTH;

  assign fetch_ready = !reset && !load_en && (!valid_q || inst_ready);
  assign accept      = fetch_valid && fetch_ready;
  assign load_we     = load_en && !reset && load_in_range;

  mem_palavras_1w1r #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk_i     (clock),
    .we_i      (load_we),
    .wr_addr_i (load_idx[AW-1:0]),
    .wr_data_i (load_data),
    .rd_addr_i (fetch_idx[AW-1:0]),
    .rd_data_o (rd_data)
  );

  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    al_d    = al_q;
    fx_d    = fx_q;
    cnt_d   = cnt_q;
    if (accept) begin
      valid_d = 1'b1;
      inst_d  = fetch_in_range ? rd_data : DATA_W'(NOP);
      al_d    = |fetch_addr[1:0];
      fx_d    = !fetch_in_range;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (inst_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      al_q    <= 1'b0;
      fx_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      al_q    <= al_d;
      fx_q    <= fx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign inst_valid       = valid_q;
  assign instrucao        = inst_q;
  assign erro_alinhamento = al_q;
  assign erro_faixa       = fx_q;
  assign num_buscas       = cnt_q;

endmodule

// File: tb/tb_memoria_instrucoes_param.sv
// Directed and randomized checks of memoria_instrucoes_param against a
// cycle-level behavioural model of fetch, load, faults and counter.
module tb_memoria_instrucoes_param;
  import mips_pkg::*;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic        clock;
  logic        reset;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_addr;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instrucao;
  logic        erro_alinhamento;
  logic        erro_faixa;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic [CNT_W-1:0] num_buscas;

  memoria_instrucoes_param #(
    .DATA_W (32),
    .ADDR_W (32),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .fetch_valid      (fetch_valid),
    .fetch_ready      (fetch_ready),
    .fetch_addr       (fetch_addr),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .instrucao        (instrucao),
    .erro_alinhamento (erro_alinhamento),
    .erro_faixa       (erro_faixa),
    .load_en          (load_en),
    .load_addr        (load_addr),
    .load_data        (load_data),
    .num_buscas       (num_buscas)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned npass = 0;
  int unsigned ntot  = 0;

  // Behavioural model state
  logic [31:0] m_mem [DEPTH];
  logic        m_valid = 1'b0;
  logic [31:0] m_inst  = '0;
  logic        m_al    = 1'b0;
  logic        m_fx    = 1'b0;
  int unsigned m_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cycle(input logic rst, input logic fv, input logic [31:0] fa,
                       input logic ir, input logic le, input logic [31:0] la,
                       input logic [31:0] ld);
    logic        exp_ready;
    int unsigned idx;
    reset       = rst;
    fetch_valid = fv;
    fetch_addr  = fa;
    inst_ready  = ir;
    load_en     = le;
    load_addr   = la;
    load_data   = ld;
    #1;
    exp_ready = !rst && !le && (!m_valid || ir);
    chk("fetch_ready", 32'(fetch_ready), 32'(exp_ready));
    @(posedge clock);
    if (rst) begin
      m_valid = 1'b0; m_inst = '0; m_al = 1'b0; m_fx = 1'b0; m_cnt = 0;
    end else begin
      if (le && (la / 4) < DEPTH) m_mem[la / 4] = ld;
      if (fv && exp_ready) begin
        idx     = fa / 4;
        m_valid = 1'b1;
        m_fx    = idx >= DEPTH;
        m_inst  = m_fx ? 32'h0 : m_mem[idx];
        m_al    = (fa % 4) != 0;
        if (m_cnt < CMAX) m_cnt++;
      end else if (ir) begin
        m_valid = 1'b0;
      end
    end
    #1;
    chk("inst_valid", 32'(inst_valid), 32'(m_valid));
    chk("instrucao", instrucao, m_inst);
    chk("erro_alinhamento", 32'(erro_alinhamento), 32'(m_al));
    chk("erro_faixa", 32'(erro_faixa), 32'(m_fx));
    chk("num_buscas", 32'(num_buscas), m_cnt);
  endtask

  localparam logic [31:0] WA = 32'h0109_5020;
  localparam logic [31:0] WB = 32'h0211_9020;
  localparam logic [31:0] WC = 32'h0294_A822;

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
    reset = 1'b1; fetch_valid = 1'b0; fetch_addr = '0; inst_ready = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;

    // Reset state
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk("reset_inst_valid", 32'(inst_valid), 32'h0);
    chk("reset_num_buscas", 32'(num_buscas), 32'h0);

    // Load two words, fetch back-to-back
    cycle(0, 0, 0, 1, 1, 0, WA);
    cycle(0, 0, 0, 1, 1, 4, WB);
    cycle(0, 1, 0, 1, 0, 0, 0);
    chk("first_fetch", instrucao, WA);
    cycle(0, 1, 4, 1, 0, 0, 0);
    chk("second_fetch", instrucao, WB);
    chk("count_two", 32'(num_buscas), 32'd2);

    // Backpressure holds response and blocks new requests
    repeat (3) cycle(0, 1, 0, 0, 0, 0, 0);
    chk("held_inst", instrucao, WB);
    cycle(0, 1, 0, 1, 0, 0, 0);
    chk("after_release", instrucao, WA);

    // Fault flags
    cycle(0, 1, 6, 1, 0, 0, 0);
    chk("misaligned_data", instrucao, WB);
    chk("misaligned_flag", 32'(erro_alinhamento), 32'h1);
    cycle(0, 1, 4 * DEPTH, 1, 0, 0, 0);
    chk("range_flag", 32'(erro_faixa), 32'h1);
    chk("range_data", instrucao, 32'h0);

    // Load priority, then read-after-load, then dropped out-of-range load
    cycle(0, 1, 8, 1, 1, 8, WC);
    cycle(0, 1, 8, 1, 0, 0, 0);
    chk("read_after_load", instrucao, WC);
    cycle(0, 0, 0, 1, 1, 4 * DEPTH, encode_r(5'd1, 5'd2, 5'd3, FN_OR));
    cycle(0, 1, 0, 1, 0, 0, 0);
    chk("oor_load_dropped", instrucao, WA);

    // Reset mid-stream with a held response, load and fetch all ignored
    cycle(0, 1, 4, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 1, 0, 32'hDEAD_BEEF);
    chk("midreset_valid", 32'(inst_valid), 32'h0);
    cycle(0, 1, 0, 1, 0, 0, 0);
    chk("mem_retained", instrucao, WA);

    // Counter saturation
    repeat (20) cycle(0, 1, 4, 1, 0, 0, 0);
    chk("count_saturated", 32'(num_buscas), 32'hF);

    // Fill memory, then randomized traffic
    for (int i = 0; i < int'(DEPTH); i++) cycle(0, 0, 0, 1, 1, 32'(i * 4), $urandom);
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 39) == 0,
            $urandom_range(0, 3) != 0,
            32'($urandom_range(0, 4 * DEPTH + 15)),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0,
            32'($urandom_range(0, 4 * DEPTH + 7)),
            $urandom);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
